rx_codeword_framer: RTL
=======================

// Module: rx_codeword_framer
// PURPOSE
//  Upstream stage of the RS decoder ping-pong pair, on the receive side of the loopback link.
//  - Hunts for a 32-bit sync word in the raw 32-bit link stream and locks to it.
//  - Unpacks each following codeword into an 8-bit AXI-Stream, MSB byte first.
//  - Marks the last codeword byte with tlast, which drives the decoder's ping-pong swap.
//  - Holds lock across isolated sync errors (flywheel); drops lock after repeated misses.
// PARAMETERS
//  CW_BYTES       255           codeword length in bytes (>=4); words/frame = 1 + ceil(CW_BYTES/4)
//  SYNC_WORD      32'h1ACF_FC1D sync marker that precedes every codeword
//  LOCK_MISS_MAX  3             consecutive bad syncs that force loss of lock (>=1)
// PORTS
//  core_clk       in   1   clock
//  rst            in   1   reset; synchronous, active-high
//  s_axis_tdata   in   32  link word; byte0 = [31:24]
//  s_axis_tvalid  in   1   link word valid
//  s_axis_tready  out  1   link word accepted
//  m_axis_tdata   out  8   codeword byte to decoder
//  m_axis_tvalid  out  1   byte valid
//  m_axis_tlast   out  1   last byte of codeword (byte index CW_BYTES-1)
//  m_axis_tready  in   1   decoder ready
//  locked         out  1   framer in lock
//  sync_miss      out  1   one-cycle pulse per bad sync word while locked
//  cw_count       out  16  codewords fully emitted since reset; wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset values (all outputs, applied on the next edge while rst=1):
//  - m_axis_tvalid=0, m_axis_tlast=0, locked=0, sync_miss=0, cw_count=0, state=HUNT.
//  - Holding register is emptied; byte, word and miss counters = 0.
//  - A reset mid-frame truncates the codeword with no tlast. This is intended.
//  States:
//  - HUNT: s_axis_tready=1. Every word is compared to SYNC_WORD.
//    - Match -> PAYLOAD, locked=1 from the next cycle, miss_cnt=0.
//    - Mismatch -> word is discarded.
//  - PAYLOAD: accept a word when hold empty OR (m_axis_tready & current byte is the last valid byte of hold).
//    - The word is loaded into the 32-bit hold register; byte_idx=0.
//    - Accepting the ceil(CW_BYTES/4)-th payload word -> SYNC.
//  - SYNC: s_axis_tready=1, independent of hold. The accepted word never enters hold.
//    - Match -> miss_cnt=0, PAYLOAD.
//    - Mismatch -> sync_miss=1 for 1 cycle, miss_cnt+1.
//      - If the new miss_cnt==LOCK_MISS_MAX -> HUNT, locked=0, miss_cnt=0.
//      - Otherwise PAYLOAD (flywheel: the next words are treated as payload).
//  Output path:
//  - m_axis_tdata = hold[31-8*byte_idx -: 8] (from registers); m_axis_tvalid = hold valid.
//  - Byte advances on m_axis_tvalid & m_axis_tready; byte_cnt 0..CW_BYTES-1.
//  - m_axis_tlast = (byte_cnt==CW_BYTES-1). On that transfer: byte_cnt=0, cw_count+1.
//  - Pad bytes in the final word (4 - CW_BYTES%4 when nonzero) are never presented.
//  - Entering HUNT from SYNC does not disturb a hold that is still draining; its bytes complete normally.
//  Handshake rules:
//  - Latency: the first byte of a word appears on the cycle after that word is accepted.
//  - Throughput: 1 byte/cycle sustained, no bubble across word or frame boundaries (the sync word is absorbed while hold drains).
//  - m_axis_* must stay stable while m_axis_tvalid=1 & m_axis_tready=0.
//  - s_axis_tready is never a function of s_axis_tvalid.
//  Boundary cases:
//  - Accepting the last payload word and emitting tlast in the same cycle is legal; cw_count increments once.
//  - A sync-word value inside the payload while locked is data, not sync.
// STRUCTURE
//  - Shared header rx_link_defs.vh: SYNC_WORD default and the state encodings (HUNT=0, PAYLOAD=1, SYNC=2).
//  - One natural sub-module, axis_32to8_unpack:
//    - Contains the hold register, byte_idx and the valid-bytes-in-last-word mask.
//    - The parent keeps the FSM, counters and status.
// TESTING
//  1. Reset, 3 junk words, then SYNC + 64 words carrying bytes 0x00..0xFE, m_tready=1
//     -> 255 bytes in order, tlast only on 0xFE, locked=1, cw_count=1, pad byte never output.
//  2. Same frame with m_axis_tready random 50%
//     -> identical byte stream, no loss/duplication, data stable under stall, s_tready=0 while hold is full and stalled.
//  3. 4 back-to-back frames, m_tready=1
//     -> 1020 consecutive bytes with m_tvalid never dropping after the first byte, cw_count=4.
//  4. Locked; frame 2 sync word = 0x00000000
//     -> one sync_miss pulse, frame 2 payload still emitted, locked=1.
//     Then 3 consecutive bad syncs -> locked=0 after the third, following words are discarded until the next SYNC_WORD.
//  5. rst asserted at byte 100 of a frame
//     -> next edge: m_tvalid=0, locked=0, cw_count=0. A subsequent clean frame is output completely and correctly.
//  6. CW_BYTES=8 build: SYNC + 2 words
//     -> 8 bytes, tlast on the 8th, no pad handling, back-to-back frames seamless.

Source files
------------

// File: rtl/rx_codeword_framer_pkg.sv
// Shared definitions for the receive codeword framer.
//  - SYNC_WORD_DEFAULT : marker that precedes every codeword on the link
//  - framer_state_e    : framer FSM states (HUNT=0, PAYLOAD=1, SYNC=2)
//  - last_byte_idx()   : index of the last valid byte in the final payload word
package rx_codeword_framer_pkg;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h1ACF_FC1D;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_SYNC    = 2'd2
  } framer_state_e;

  // Bytes beyond this index in the last word of a codeword are pad.
  function automatic logic [1:0] last_byte_idx(input int unsigned cw_bytes);
    int unsigned rem;
    rem = cw_bytes % 4;
    return (rem == 0) ? 2'd3 : 2'(rem - 1);
  endfunction

endpackage

// File: rtl/rx_codeword_framer_unpack.sv
// 32-bit to 8-bit unpacker: one hold register drained MSB byte first.
// Ports:
//  core_clk, rst     clock, synchronous active-high reset
//  load              capture load_data into hold (only when can_load)
//  load_data         32-bit word, byte0 = [31:24]
//  load_last_idx     index of the last valid byte of load_data (pad masking)
//  m_axis_tdata/tvalid/tready   byte stream out
//  can_load          hold empty, or its last valid byte leaves this cycle
module axis_32to8_unpack (
  input  logic        core_clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [1:0]  load_last_idx,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        can_load
);

  logic [31:0] hold;
  logic        hold_valid;
  logic [1:0]  byte_idx;
  logic [1:0]  last_idx;
  logic        at_last;

  assign at_last       = (byte_idx == last_idx);
  assign m_axis_tvalid = hold_valid;
  assign can_load      = ~hold_valid | (m_axis_tready & at_last);

  always_comb begin
    m_axis_tdata = hold[31:24];
    case (byte_idx)
      2'd0:    m_axis_tdata = hold[31:24];
      2'd1:    m_axis_tdata = hold[23:16];
      2'd2:    m_axis_tdata = hold[15:8];
      default: m_axis_tdata = hold[7:0];
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      byte_idx   <= '0;
      last_idx   <= 2'd3;
    end else if (load) begin
      // load is only issued with can_load, so it may replace a finishing word
      hold       <= load_data;
      hold_valid <= 1'b1;
      byte_idx   <= '0;
      last_idx   <= load_last_idx;
    end else if (hold_valid && m_axis_tready) begin
      if (at_last) hold_valid <= 1'b0;
      else         byte_idx   <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/rx_codeword_framer.sv
// Receive codeword framer: hunts for the sync word, locks, and unpacks each
// codeword into an 8-bit AXI-Stream with tlast on the last codeword byte.
// A flywheel keeps lock across isolated bad syncs; LOCK_MISS_MAX consecutive
// misses return to hunting.
// Ports:
//  core_clk, rst                      clock, synchronous active-high reset
//  s_axis_tdata/tvalid/tready         32-bit link words in
//  m_axis_tdata/tvalid/tlast/tready   codeword bytes out
//  locked                             framer in lock
//  sync_miss                          1-cycle pulse per bad sync while locked
//  cw_count                           codewords fully emitted (wraps)
module rx_codeword_framer
  import rx_codeword_framer_pkg::*;
#(
  parameter int unsigned CW_BYTES      = 255,
  parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int unsigned LOCK_MISS_MAX = 3
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        locked,
  output logic        sync_miss,
  output logic [15:0] cw_count
);

  localparam int unsigned NUM_WORDS = (CW_BYTES + 3) / 4;
  localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS - 1);
  localparam logic [15:0] LAST_BYTE = 16'(CW_BYTES - 1);
  localparam logic [7:0]  MISS_MAX  = 8'(LOCK_MISS_MAX);
  localparam logic [1:0]  LAST_IDX  = last_byte_idx(CW_BYTES);

  framer_state_e state, state_n;
  logic [15:0]   word_cnt, word_cnt_n;
  logic [7:0]    miss_cnt, miss_cnt_n;
  logic          locked_n;
  logic          sync_miss_n;
  logic [15:0]   byte_cnt;

  logic          sync_hit;
  logic          load;
  logic [1:0]    load_last_idx;
  logic          can_load;
  logic          out_xfer;

  assign sync_hit     = (s_axis_tdata == SYNC_WORD);
  assign out_xfer     = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast = (byte_cnt == LAST_BYTE);

  axis_32to8_unpack u_unpack (
    .core_clk      (core_clk),
    .rst           (rst),
    .load          (load),
    .load_data     (s_axis_tdata),
    .load_last_idx (load_last_idx),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .can_load      (can_load)
  );

  always_comb begin
    state_n       = state;
    word_cnt_n    = word_cnt;
    miss_cnt_n    = miss_cnt;
    locked_n      = locked;
    sync_miss_n   = 1'b0;
    s_axis_tready = 1'b0;
    load          = 1'b0;
    load_last_idx = 2'd3;
    unique case (state)
      ST_HUNT: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && sync_hit) begin
          state_n    = ST_PAYLOAD;
          locked_n   = 1'b1;
          miss_cnt_n = '0;
          word_cnt_n = '0;
        end
      end
      ST_PAYLOAD: begin
        s_axis_tready = can_load;
        if (s_axis_tvalid && can_load) begin
          load = 1'b1;
          if (word_cnt == LAST_WORD) begin
            load_last_idx = LAST_IDX;
            word_cnt_n    = '0;
            state_n       = ST_SYNC;
          end else begin
            word_cnt_n = word_cnt + 16'd1;
          end
        end
      end
      ST_SYNC: begin
        // The sync word is absorbed while the last payload word drains.
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          word_cnt_n = '0;
          if (sync_hit) begin
            miss_cnt_n = '0;
            state_n    = ST_PAYLOAD;
          end else begin
            sync_miss_n = 1'b1;
            if (miss_cnt + 8'd1 == MISS_MAX) begin
              miss_cnt_n = '0;
              locked_n   = 1'b0;
              state_n    = ST_HUNT;
            end else begin
              miss_cnt_n = miss_cnt + 8'd1;
              state_n    = ST_PAYLOAD;
            end
          end
        end
      end
      default: state_n = ST_HUNT;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      word_cnt  <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      sync_miss <= 1'b0;
      byte_cnt  <= '0;
      cw_count  <= '0;
    end else begin
      state     <= state_n;
      word_cnt  <= word_cnt_n;
      miss_cnt  <= miss_cnt_n;
      locked    <= locked_n;
      sync_miss <= sync_miss_n;
      if (out_xfer) begin
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
          cw_count <= cw_count + 16'd1;
        end else begin
          byte_cnt <= byte_cnt + 16'd1;
        end
      end
    end
  end

endmodule
